pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: freezes on data-memory wait, flushes on
// branch redirect, inserts one bubble per load-use, and keeps saturating stats.
module pipe_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hz_stall,
    input  logic          br_taken,
    input  logic          dmem_busy,
    output logic          pc_we,
    output logic          ifid_we,
    output logic          ifid_flush,
    output logic          idex_we,
    output logic          idex_flush,
    output logic          exmem_we,
    output logic          memwb_we,
    output logic          mem_timeout,
    output logic [CW-1:0] stall_cycles,
    output logic [CW-1:0] flush_count
);

    localparam int BW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MEM_WAIT,
        FLUSH
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [BW-1:0] r_busy_cnt;
    logic [BW-1:0] w_busy_nxt;
    logic          r_timeout;
    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] r_flush_cnt;

    logic w_pc_we, w_ifid_we, w_ifid_flush, w_idex_we, w_idex_flush;
    logic w_exmem_we, w_memwb_we;
    logic w_flush_evt;
    logic w_hz_honoured;

    // ID holds a bubble or a flushed NOP after LU_STALL/FLUSH, so hz_stall is stale there
    assign w_hz_honoured = (r_state == RUN) || (r_state == MEM_WAIT);

    always_comb begin
        w_next_state = RUN;
        w_pc_we      = 1'b1;
        w_ifid_we    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_we    = 1'b1;
        w_idex_flush = 1'b0;
        w_exmem_we   = 1'b1;
        w_memwb_we   = 1'b1;
        w_flush_evt  = 1'b0;
        if (reset) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_we    = 1'b0;
            w_idex_flush = 1'b1;
            w_exmem_we   = 1'b0;
            w_memwb_we   = 1'b0;
        end else if (dmem_busy) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_we    = 1'b0;
            w_exmem_we   = 1'b0;
            w_memwb_we   = 1'b0;
            w_next_state = MEM_WAIT;
        end else if (br_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_flush_evt  = 1'b1;
            w_next_state = FLUSH;
        end else if (hz_stall && w_hz_honoured) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_flush = 1'b1;
            w_next_state = LU_STALL;
        end
    end

    always_comb begin
        w_busy_nxt = '0;
        if (dmem_busy) begin
            w_busy_nxt = (r_busy_cnt == BW'(TIMEOUT)) ? r_busy_cnt : r_busy_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_busy_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_busy_cnt <= w_busy_nxt;
            if (dmem_busy && (w_busy_nxt == BW'(TIMEOUT))) begin
                r_timeout <= 1'b1;
            end
            if (!w_pc_we && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CW'(1);
            end
        end
    end

    assign pc_we        = w_pc_we;
    assign ifid_we      = w_ifid_we;
    assign ifid_flush   = w_ifid_flush;
    assign idex_we      = w_idex_we;
    assign idex_flush   = w_idex_flush;
    assign exmem_we     = w_exmem_we;
    assign memwb_we     = w_memwb_we;
    assign mem_timeout  = r_timeout;
    assign stall_cycles = r_stall_cnt;
    assign flush_count  = r_flush_cnt;

endmodule
